// File: rtl/io_input_conditioner.sv
// Conditions raw external pins for the io block: 2-flop synchronizer, per-bit
// debounce qualification, and sticky rising-edge flags with a masked clear.
module io_input_conditioner #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 4,
  localparam int CNT_W          = $clog2(DEBOUNCE_CYCLES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pins_in,
  input  logic             clear_en,
  input  logic [WIDTH-1:0] clear_mask,
  output logic [WIDTH-1:0] io_input,
  output logic [WIDTH-1:0] edge_flags,
  output logic             any_edge
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;
  logic [CNT_W-1:0] cnt [WIDTH];
  logic [WIDTH-1:0] fire;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] clr;

  // A bit qualifies on the edge where it has differed for DEBOUNCE_CYCLES edges.
  always_comb begin
    fire = '0;
    for (int i = 0; i < WIDTH; i++) begin
      fire[i] = (sync2[i] != io_input[i]) && (cnt[i] == CNT_LAST);
    end
  end

  assign rise     = fire & sync2;
  assign clr      = clear_en ? clear_mask : '0;
  assign any_edge = |edge_flags;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1      <= '0;
      sync2      <= '0;
      io_input   <= '0;
      edge_flags <= '0;
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      sync1 <= pins_in;
      sync2 <= sync1;
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == io_input[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          io_input[i] <= sync2[i];
          cnt[i]      <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
      // Set beats clear so a rising event coinciding with a clear is kept.
      edge_flags <= (edge_flags & ~clr) | rise;
    end
  end

endmodule

// File: tb/tb_io_input_conditioner.sv
// Randomized and directed bench for io_input_conditioner, checked against a
// sliding-window reference model of the debounce rule.
module tb_io_input_conditioner;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] pins_in;
  logic         clear_en;
  logic [W-1:0] clear_mask;
  logic [W-1:0] io_input;
  logic [W-1:0] edge_flags;
  logic         any_edge;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: pipeline of sampled pins and a window of the last D
  // synchronized values; a bit flips when every value in the window differs.
  logic [W-1:0] m_s1, m_s2, m_io, m_flags;
  logic [W-1:0] win [$];

  io_input_conditioner #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst        (rst),
    .pins_in    (pins_in),
    .clear_en   (clear_en),
    .clear_mask (clear_mask),
    .io_input   (io_input),
    .edge_flags (edge_flags),
    .any_edge   (any_edge)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_s1 = '0; m_s2 = '0; m_io = '0; m_flags = '0;
    win.delete();
    for (int j = 0; j < D; j++) win.push_back('0);
  endtask

  task automatic step();
    logic [W-1:0] fire, rise, clr;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      win.push_front(m_s2);
      void'(win.pop_back());
      fire = '1;
      foreach (win[j]) fire &= (win[j] ^ m_io);
      rise    = fire & ~m_io;
      clr     = clear_en ? clear_mask : '0;
      m_flags = (m_flags & ~clr) | rise;
      m_io    = m_io ^ fire;
      m_s2    = m_s1;
      m_s1    = pins_in;
    end
    #1;
  endtask

  task automatic clear_all();
    clear_en = 1'b1; clear_mask = '1;
    step();
    clear_en = 1'b0; clear_mask = '0;
  endtask

  task automatic test_reset();
    pins_in = 8'hFF; rst = 1'b1;
    repeat (3) step();
    n_checks++;
    if (io_input !== 8'h00 || edge_flags !== 8'h00 || any_edge !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_state: io=%h flags=%h any=%b, required 00/00/0", io_input, edge_flags, any_edge);
    end
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j == 5) begin
        n_checks++;
        if (io_input !== 8'h00) begin
          n_errors++;
          $display("FAIL reset_release_early: io=%h, required 00 at edge 5", io_input);
        end
      end
    end
    n_checks++;
    if (io_input !== 8'hFF || edge_flags !== 8'hFF || any_edge !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_release: io=%h flags=%h any=%b, required FF/FF/1", io_input, edge_flags, any_edge);
    end
    clear_all();
    n_checks++;
    if (edge_flags !== 8'h00 || any_edge !== 1'b0) begin
      n_errors++;
      $display("FAIL clear_all: flags=%h any=%b, required 00/0", edge_flags, any_edge);
    end
  endtask

  task automatic test_glitch();
    pins_in = 8'h00;
    repeat (8) step();
    pins_in = 8'h01;
    repeat (3) step();
    pins_in = 8'h00;
    repeat (8) step();
    n_checks++;
    if (io_input !== 8'h00 || edge_flags !== 8'h00) begin
      n_errors++;
      $display("FAIL glitch_filter: io=%h flags=%h, required 00/00", io_input, edge_flags);
    end
    pins_in = 8'h01;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j == 5) begin
        n_checks++;
        if (io_input[0] !== 1'b0) begin
          n_errors++;
          $display("FAIL latency_early: io[0]=%b, required 0 at edge 5", io_input[0]);
        end
      end
    end
    n_checks++;
    if (io_input !== 8'h01 || edge_flags !== 8'h01) begin
      n_errors++;
      $display("FAIL latency: io=%h flags=%h, required 01/01", io_input, edge_flags);
    end
  endtask

  task automatic test_clear_set();
    pins_in = 8'h03;
    repeat (6) step();
    n_checks++;
    if (edge_flags !== 8'h03) begin
      n_errors++;
      $display("FAIL flags_03: flags=%h, required 03", edge_flags);
    end
    clear_en = 1'b1; clear_mask = 8'h01;
    step();
    clear_en = 1'b0; clear_mask = 8'h00;
    n_checks++;
    if (edge_flags !== 8'h02) begin
      n_errors++;
      $display("FAIL masked_clear: flags=%h, required 02", edge_flags);
    end
    pins_in = 8'h07;
    repeat (5) step();
    clear_en = 1'b1; clear_mask = 8'h04;
    step();
    clear_en = 1'b0; clear_mask = 8'h00;
    n_checks++;
    if (edge_flags !== 8'h06 || io_input !== 8'h07) begin
      n_errors++;
      $display("FAIL set_wins: flags=%h io=%h, required 06/07", edge_flags, io_input);
    end
    clear_en = 1'b1; clear_mask = 8'h00;
    step();
    clear_en = 1'b0; clear_mask = 8'hFF;
    step();
    clear_mask = 8'h00;
    n_checks++;
    if (edge_flags !== 8'h06) begin
      n_errors++;
      $display("FAIL clear_noop: flags=%h, required 06", edge_flags);
    end
  endtask

  task automatic test_falling();
    pins_in = 8'h80;
    repeat (8) step();
    clear_all();
    n_checks++;
    if (io_input !== 8'h80 || edge_flags !== 8'h00) begin
      n_errors++;
      $display("FAIL falling_setup: io=%h flags=%h, required 80/00", io_input, edge_flags);
    end
    pins_in = 8'h00;
    repeat (6) step();
    n_checks++;
    if (io_input !== 8'h00 || edge_flags !== 8'h00 || any_edge !== 1'b0) begin
      n_errors++;
      $display("FAIL falling_edge: io=%h flags=%h any=%b, required 00/00/0", io_input, edge_flags, any_edge);
    end
  endtask

  task automatic test_multibit();
    pins_in = 8'h0F;
    for (int j = 0; j < 10; j++) begin
      step();
      pins_in[0] = ~pins_in[0];
    end
    n_checks++;
    if (io_input !== 8'h0E || edge_flags !== 8'h0E) begin
      n_errors++;
      $display("FAIL multibit: io=%h flags=%h, required 0E/0E", io_input, edge_flags);
    end
  endtask

  task automatic test_reset_mid();
    pins_in = 8'h00;
    repeat (8) step();
    clear_all();
    pins_in = 8'h08;
    repeat (3) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int j = 1; j <= 6; j++) begin
      step();
      if (j == 5) begin
        n_checks++;
        if (io_input[3] !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_mid_early: io[3]=%b, required 0 at edge 5", io_input[3]);
        end
      end
    end
    n_checks++;
    if (io_input !== 8'h08 || edge_flags !== 8'h08) begin
      n_errors++;
      $display("FAIL reset_mid: io=%h flags=%h, required 08/08", io_input, edge_flags);
    end
  endtask

  task automatic test_random();
    int hold = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hold == 0) begin
        pins_in = pins_in ^ W'($urandom);
        hold = $urandom_range(1, 7);
      end
      hold--;
      clear_en   = ($urandom_range(0, 7) == 0);
      clear_mask = W'($urandom);
      rst        = ($urandom_range(0, 299) == 0);
      step();
      n_checks++;
      if (io_input !== m_io || edge_flags !== m_flags || any_edge !== (|m_flags)) begin
        n_errors++;
        $display("FAIL random cycle %0d: io=%h flags=%h any=%b, required %h/%h/%b",
                 c, io_input, edge_flags, any_edge, m_io, m_flags, |m_flags);
      end
    end
    rst = 1'b0; clear_en = 1'b0; clear_mask = '0;
  endtask

  initial begin
    rst = 1'b1; pins_in = '0; clear_en = 1'b0; clear_mask = '0;
    model_reset();
    test_reset();
    test_glitch();
    test_clear_set();
    test_falling();
    test_multibit();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/io_input_conditioner.md
Name: io_input_conditioner

Overview:
Conditions raw external input pins before they reach the `io` block's `io_input` port. Each bit goes through a 2-flop synchronizer, then a per-bit debounce counter. A sticky rising-edge flag register is kept alongside; software clears it through a masked clear pulse decoded from an IO store. The block sits directly upstream of `io`; its `io_input` output wires straight to `io.io_input`.

Parameters:
WIDTH, 8, number of input bits; must match the `io` data width.
DEBOUNCE_CYCLES, 4, consecutive cycles a synchronized value must differ from the debounced value before it is accepted; legal range 1..255.
CNT_W, $clog2(DEBOUNCE_CYCLES+1), derived width of each per-bit counter; not overridden.

Ports:
clk  input  1  system clock; all state updates on posedge clk.
rst  input  1  synchronous, active-high reset.
pins_in  input  WIDTH  raw asynchronous external inputs.
clear_en  input  1  one-cycle pulse requesting an edge-flag clear.
clear_mask  input  WIDTH  bits of edge_flags to clear while clear_en=1.
io_input  output  WIDTH  debounced stable value; feeds io.io_input.
edge_flags  output  WIDTH  sticky per-bit rising-edge flags (registered).
any_edge  output  1  combinational OR of edge_flags.

Behaviour:
- Reset (rst=1 at a posedge): sync1, sync2, io_input, edge_flags and all counters go to 0. any_edge=0. Reset overrides all other activity in that cycle, including clear_en.
- Synchronizer: sync1 <= pins_in; sync2 <= sync1. No logic sits between the two flops.
- Per-bit debounce, for bit i on each posedge, not in reset:
  - sync2[i]==io_input[i]: cnt[i] <= 0.
  - sync2[i]!=io_input[i] and cnt[i] < DEBOUNCE_CYCLES-1: cnt[i] <= cnt[i]+1.
  - sync2[i]!=io_input[i] and cnt[i]==DEBOUNCE_CYCLES-1: io_input[i] <= sync2[i]; cnt[i] <= 0.
- Latency: if pins_in changes and stays stable, and the first sampling edge is edge k, io_input updates at edge k+1+DEBOUNCE_CYCLES. With the default, that is edge k+5, i.e. 6 posedges counting edge k.
- Glitch filter: a sync2 deviation lasting fewer than DEBOUNCE_CYCLES cycles leaves io_input unchanged. The counter restarts from 0 on the next deviation and never accumulates across gaps.
- DEBOUNCE_CYCLES=1: io_input[i] follows sync2[i] with one cycle delay; counters are unused and are held at 0.
- Bits are fully independent; simultaneous transitions on several bits are each handled on their own counter.
- Edge flags, per bit:
  - set = (the debounce update fires this edge) and (io_input[i] 0->1). A falling transition never sets a flag.
  - clr = clear_en & clear_mask[i].
  - Priority: set wins over clr in the same cycle, so no event is lost. Otherwise clr clears the flag; otherwise the flag holds.
- clear_en with clear_mask=0 is a no-op. clear_mask is ignored when clear_en=0.
- Reset mid-debounce discards the pending count. Pins held high through reset release re-qualify from count 0, then raise io_input and set the edge flag (an edge relative to the reset value 0).
- No counter wrap is possible: counters saturate by construction at DEBOUNCE_CYCLES-1 and then reload to 0.

Test Plan:
- Reset: hold pins_in=8'hFF with rst=1 for 3 cycles -> io_input=8'h00, edge_flags=8'h00, any_edge=0. Release rst -> io_input=8'hFF exactly 6 posedges after the first post-reset edge; edge_flags=8'hFF; any_edge=1.
- Latency/glitch: pins_in[0] high for 3 cycles then low (D=4) -> io_input[0] stays 0 and edge_flags[0] stays 0. Then hold it high -> io_input[0]=1 on the 6th posedge after first sampling; edge_flags=8'h01.
- Clear vs set: edge_flags=8'h03, pulse clear_en with clear_mask=8'h01 -> edge_flags=8'h02. Pulse clear_en with mask=8'h04 on the same edge that bit 2 qualifies rising -> edge_flags=8'h06 (set wins).
- Falling edge: io_input=8'h80 with flags cleared, drop pins_in[7] -> io_input=8'h00 after 6 cycles; edge_flags stays 8'h00.
- Multi-bit independence: pins_in 8'h00->8'h0F at cycle 0, then bit 0 toggles every cycle -> io_input=8'h0E after qualification; bit 0 never qualifies; edge_flags=8'h0E.
- Reset mid-debounce: pins_in[3] high for 3 cycles, assert rst for 1 cycle, keep pins high -> io_input[3] rises 6 posedges after the reset edge, not earlier.
